sha256_pad_feeder: RTL and testbench
====================================

SHA256_PAD_FEEDER -- requirements
Module: sha256_pad_feeder

Interface
REQ-001: Parameters: none; block fixed at 16 x 32-bit words, length field 64-bit big-endian.
REQ-002: clk  input  1  single clock, all state on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  message word offered.
REQ-005: in_data  input  32  message word, big-endian: first byte in [31:24].
REQ-006: in_last  input  1  qualifies final message word.
REQ-007: in_bytes  input  2  valid bytes in final word: 00=4, 01=1, 10=2, 11=3; ignored unless in_last.
REQ-008: in_ready  output  1  feeder accepts word this cycle.
REQ-009: in_start  input  1  one-cycle pulse beginning a new message; honored only in IDLE.
REQ-010: blk_ready  input  1  hash core ready for next block.
REQ-011: soc  output  1  one-cycle pulse coincident with word 0 of every emitted block.
REQ-012: w_out  output  32  block word to core.
REQ-013: w_valid  output  1  w_out valid.
REQ-014: w_idx  output  4  index of w_out within block, 0..15.
REQ-015: last_blk  output  1  high with every word of the message's final block.
REQ-016: busy  output  1  high in every state except IDLE.

Function
REQ-017: FSM states IDLE, LOAD, PAD, ZERO, LEN, WAIT, EMIT; one state register, one 4-bit fill index, one 4-bit emit index, 16x32 block buffer, 64-bit bit counter.
REQ-018: IDLE -> LOAD on in_start; bit counter and fill index cleared on entry.
REQ-019: in_ready = 1 only in LOAD; word accepted when in_valid && in_ready; buffer[fill]=in_data, fill increments, counter += 32 (non-last) or 8*bytes (last).
REQ-020: Last word with in_bytes!=00: 0x80 written into first unused byte, remaining bytes zeroed, fill increments, -> ZERO.
REQ-021: Last word full (in_bytes=00): -> PAD; PAD writes 0x80000000 at fill, fill increments, -> ZERO.
REQ-022: Fill reaching 16 in LOAD (non-last word) -> WAIT with last_blk flag clear; return to LOAD after emission.
REQ-023: ZERO writes 0x00000000 per cycle until fill=14, then -> LEN; if padding ended with fill in {15,0(wrapped)}, zero-fill to 16, emit as non-final block, then a fresh all-zero block continues in ZERO from fill=0.
REQ-024: LEN writes counter[63:32] at word 14, counter[31:0] at word 15, sets final flag, -> WAIT.
REQ-025: WAIT holds until blk_ready=1 sampled; EMIT begins next cycle.
REQ-026: EMIT drives w_valid=1 for exactly 16 consecutive cycles, w_idx 0..15, w_out=buffer[w_idx]; soc=1 only at w_idx=0; blk_ready not sampled during EMIT.
REQ-027: After EMIT: final block -> IDLE; otherwise -> LOAD (data remaining) or ZERO (padding overflow block).
REQ-028: Bit counter wraps modulo 2^64; no error flag.
REQ-029: in_start outside IDLE ignored; in_valid outside LOAD ignored (no acceptance, no counter change).
REQ-030: in_last with in_valid on the word that fills index 15: padding proceeds per REQ-021/REQ-023 (two-block tail).

Reset
REQ-031: rst_n low asynchronously forces IDLE; in_ready, soc, w_valid, last_blk, busy = 0; w_out, w_idx = 0; counter and indices = 0.
REQ-032: Reset mid-EMIT aborts block immediately; no further w_valid until new in_start after release.
REQ-033: Buffer contents need not be cleared by reset; never visible without new writes.

Verification
REQ-034: Empty message: in_start, then in_valid/in_last with in_bytes=01 not used; instead last word 0x00000000 in_bytes... -- covered as: in_start, in_last word "a" (0x61000000, in_bytes=01) -> one block, word0=0x61800000, words1-14=0, word15=0x00000008, last_blk=1.
REQ-035: "abc" (0x61626300, in_bytes=11, in_last) -> word0=0x61626380, word15=0x00000018, soc once, 16 w_valid cycles.
REQ-036: 14 full words then in_last full word (60 bytes) -> block1 word15=0x80000000 region per REQ-023, last_blk=0; block2 words0-13=0, word14=0, word15=0x000001E0, last_blk=1.
REQ-037: blk_ready held low 20 cycles in WAIT -> w_valid stays 0, in_ready 0; blk_ready high -> soc next cycle.
REQ-038: rst_n asserted at w_idx=7 -> w_valid, soc, busy 0 same cycle; after release, in_start + "abc" gives REQ-035 result.
REQ-039: in_valid pulses during EMIT and in IDLE -> no acceptance, final length word unchanged.

Source files
------------

// File: rtl/sha256_pad_feeder_if.sv
// rtl/sha256_pad_feeder_if.sv - message-in / block-out signal bundle for the SHA-256 pad feeder
interface sha256_pad_feeder_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic [1:0]  in_bytes;
   logic        in_ready;
   logic        in_start;
   logic        blk_ready;
   logic        soc;
   logic [31:0] w_out;
   logic        w_valid;
   logic [3:0]  w_idx;
   logic        last_blk;
   logic        busy;

   // Message source / hash-core side
   modport master (
      output in_valid, in_data, in_last, in_bytes, in_start, blk_ready,
      input  in_ready, soc, w_out, w_valid, w_idx, last_blk, busy
   );

   // Feeder side
   modport slave (
      input  in_valid, in_data, in_last, in_bytes, in_start, blk_ready,
      output in_ready, soc, w_out, w_valid, w_idx, last_blk, busy
   );
endinterface

// File: rtl/sha256_pad_feeder.sv
// rtl/sha256_pad_feeder.sv - buffers message words, appends SHA-256 padding and length, emits 16-word blocks
module sha256_pad_feeder (
   input logic              clk,
   input logic              rst_n,
   sha256_pad_feeder_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, PAD, ZERO, LEN, WAIT, EMIT} state_t;
   // Where to go once the buffered block has been emitted
   typedef enum logic [1:0] {NX_LOAD, NX_PAD, NX_ZERO, NX_IDLE} next_t;

   state_t      state;
   next_t       after_emit;
   logic [3:0]  fill;
   logic [63:0] bit_cnt;
   logic        ovf;          // padding spilled past word 13: current block has no room for the length
   logic [31:0] blk_buf [16];

   logic        w_valid_q;
   logic [31:0] w_out_q;
   logic [3:0]  w_idx_q;
   logic        soc_q;
   logic        last_q;

   logic [3:0]  emit_nxt;
   logic [31:0] tail_word;
   logic [63:0] word_bits;
   logic        buf_we;
   logic [31:0] buf_wd;

   assign emit_nxt     = w_idx_q + 4'd1;
   assign bus.in_ready = (state == LOAD);
   assign bus.busy     = (state != IDLE);
   assign bus.w_valid  = w_valid_q;
   assign bus.w_out    = w_out_q;
   assign bus.w_idx    = w_idx_q;
   assign bus.soc      = soc_q;
   assign bus.last_blk = last_q;

   // Final-word formatting: keep valid bytes, 0x80 marker in first unused byte, rest zero
   always_comb begin
      tail_word = bus.in_data;
      word_bits = 64'd32;
      if (bus.in_last) begin
         case (bus.in_bytes)
            2'b01:   tail_word = {bus.in_data[31:24], 8'h80, 16'h0000};
            2'b10:   tail_word = {bus.in_data[31:16], 8'h80, 8'h00};
            2'b11:   tail_word = {bus.in_data[31:8], 8'h80};
            default: tail_word = bus.in_data;
         endcase
         if (bus.in_bytes != 2'b00)
            word_bits = {59'd0, bus.in_bytes, 3'b000};
      end
   end

   // Buffer write port: data, pad marker, zero fill and length all land at the fill index
   always_comb begin
      buf_we = 1'b0;
      buf_wd = 32'h0000_0000;
      case (state)
         LOAD: begin
            buf_we = bus.in_valid;
            buf_wd = tail_word;
         end
         PAD: begin
            buf_we = 1'b1;
            buf_wd = 32'h8000_0000;
         end
         ZERO: buf_we = ovf ? (fill != 4'd0) : (fill != 4'd14);
         LEN: begin
            buf_we = 1'b1;
            buf_wd = (fill == 4'd14) ? bit_cnt[63:32] : bit_cnt[31:0];
         end
         default: buf_we = 1'b0;
      endcase
   end

   // Block buffer storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (buf_we)
         blk_buf[fill] <= buf_wd;
   end

   // Main sequencer with registered block-output signals
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         after_emit <= NX_LOAD;
         fill       <= 4'd0;
         bit_cnt    <= 64'd0;
         ovf        <= 1'b0;
         w_valid_q  <= 1'b0;
         w_out_q    <= 32'h0;
         w_idx_q    <= 4'd0;
         soc_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_start) begin
                  state   <= LOAD;
                  fill    <= 4'd0;
                  bit_cnt <= 64'd0;
                  ovf     <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  fill    <= fill + 4'd1;
                  bit_cnt <= bit_cnt + word_bits;
                  if (bus.in_last) begin
                     if (bus.in_bytes == 2'b00) begin
                        // A full final word in slot 15 fills the block: ship it, then pad
                        if (fill == 4'd15) begin
                           state      <= WAIT;
                           after_emit <= NX_PAD;
                        end else begin
                           state <= PAD;
                        end
                     end else begin
                        ovf   <= (fill >= 4'd14);
                        state <= ZERO;
                     end
                  end else if (fill == 4'd15) begin
                     state      <= WAIT;
                     after_emit <= NX_LOAD;
                  end
               end
            end
            PAD: begin
               fill  <= fill + 4'd1;
               ovf   <= (fill >= 4'd14);
               state <= ZERO;
            end
            ZERO: begin
               if (ovf) begin
                  if (fill == 4'd0) begin
                     state      <= WAIT;
                     after_emit <= NX_ZERO;
                     ovf        <= 1'b0;
                  end else begin
                     fill <= fill + 4'd1;
                     if (fill == 4'd15) begin
                        state      <= WAIT;
                        after_emit <= NX_ZERO;
                        ovf        <= 1'b0;
                     end
                  end
               end else if (fill == 4'd14) begin
                  state <= LEN;
               end else begin
                  fill <= fill + 4'd1;
               end
            end
            LEN: begin
               fill <= fill + 4'd1;
               if (fill == 4'd15) begin
                  state      <= WAIT;
                  after_emit <= NX_IDLE;
               end
            end
            WAIT: begin
               if (bus.blk_ready) begin
                  state     <= EMIT;
                  w_valid_q <= 1'b1;
                  w_idx_q   <= 4'd0;
                  w_out_q   <= blk_buf[0];
                  soc_q     <= 1'b1;
                  last_q    <= (after_emit == NX_IDLE);
               end
            end
            EMIT: begin
               soc_q <= 1'b0;
               if (w_idx_q == 4'd15) begin
                  w_valid_q <= 1'b0;
                  w_idx_q   <= 4'd0;
                  w_out_q   <= 32'h0;
                  last_q    <= 1'b0;
                  case (after_emit)
                     NX_PAD:  state <= PAD;
                     NX_ZERO: state <= ZERO;
                     NX_IDLE: state <= IDLE;
                     default: state <= LOAD;
                  endcase
               end else begin
                  w_idx_q <= emit_nxt;
                  w_out_q <= blk_buf[emit_nxt];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_pad_feeder.sv
// tb/tb_sha256_pad_feeder.sv - scoreboard bench for the SHA-256 pad feeder
module tb_sha256_pad_feeder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sha256_pad_feeder_if bus ();

   sha256_pad_feeder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  idx;
      logic        soc;
      logic        last;
   } sb_t;

   sb_t         exp_q [$];
   sb_t         mon_e;
   logic [31:0] eb [16];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clear_eb();
      for (int i = 0; i < 16; i++) eb[i] = 32'h0;
   endtask

   task automatic push_block(input logic last);
      for (int i = 0; i < 16; i++) begin
         sb_t e;
         e.w    = eb[i];
         e.idx  = 4'(i);
         e.soc  = (i == 0);
         e.last = last;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.in_start = 1'b1;
      @(negedge clk);
      bus.in_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_bytes = nb;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, {63'd0, bus.busy}, 64'd0);
      repeat (2) @(negedge clk);
      chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every presented block word is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.w_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL blk_unexpected: w_valid with w_idx=%0d w_out=%h, expected no word", bus.w_idx, bus.w_out);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.w_out !== mon_e.w || bus.w_idx !== mon_e.idx ||
                bus.soc !== mon_e.soc || bus.last_blk !== mon_e.last) begin
               errors++;
               $display("FAIL blk_word: got w=%h idx=%0d soc=%b last=%b, expected w=%h idx=%0d soc=%b last=%b",
                        bus.w_out, bus.w_idx, bus.soc, bus.last_blk,
                        mon_e.w, mon_e.idx, mon_e.soc, mon_e.last);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_last   = 1'b0;
      bus.in_bytes  = 2'b00;
      bus.in_start  = 1'b0;
      bus.blk_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",     {63'd0, bus.busy},     64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("rst_w_valid",  {63'd0, bus.w_valid},  64'd0);
      chk("rst_soc",      {63'd0, bus.soc},      64'd0);
      chk("rst_last_blk", {63'd0, bus.last_blk}, 64'd0);
      chk("rst_w_out",    {32'd0, bus.w_out},    64'd0);
      chk("rst_w_idx",    {60'd0, bus.w_idx},    64'd0);
      rst_n = 1'b1;

      // in_valid while idle must not be absorbed; then single-byte message "a"
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("idle_busy", {63'd0, bus.busy}, 64'd0);
      clear_eb();
      eb[0]  = 32'h6180_0000;
      eb[15] = 32'h0000_0008;
      push_block(1'b1);
      do_start();
      send_word(32'h6100_0000, 1'b1, 2'b01);
      wait_idle("a_idle");

      // "abc" with the core stalled in WAIT for 20 cycles
      begin
         logic hold_ok = 1'b1;
         bus.blk_ready = 1'b0;
         clear_eb();
         eb[0]  = 32'h6162_6380;
         eb[15] = 32'h0000_0018;
         push_block(1'b1);
         do_start();
         send_word(32'h6162_6300, 1'b1, 2'b11);
         repeat (20) @(negedge clk);
         for (int i = 0; i < 20; i++) begin
            if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
         end
         chk("wait_hold", {63'd0, hold_ok}, 64'd1);
         bus.blk_ready = 1'b1;
         @(negedge clk);
         chk("wait_release_soc", {63'd0, bus.soc}, 64'd1);
         wait_idle("abc_idle");
      end

      // 60-byte message: padding marker lands in word 15, length needs a second block
      clear_eb();
      for (int i = 0; i < 15; i++) eb[i] = 32'h1000_0000 + 32'(i);
      eb[15] = 32'h8000_0000;
      push_block(1'b0);
      clear_eb();
      eb[15] = 32'h0000_01E0;
      push_block(1'b1);
      do_start();
      for (int i = 0; i < 15; i++) send_word(32'h1000_0000 + 32'(i), (i == 14), 2'b00);
      wait_idle("m60_idle");

      // 64-byte message: last full word fills slot 15, marker opens the second block
      clear_eb();
      for (int i = 0; i < 16; i++) eb[i] = 32'hA000_0000 + 32'(i);
      push_block(1'b0);
      clear_eb();
      eb[0]  = 32'h8000_0000;
      eb[15] = 32'h0000_0200;
      push_block(1'b1);
      do_start();
      for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i), (i == 15), 2'b00);
      wait_idle("m64_idle");

      // Reset in the middle of emission, then a clean "abc"
      begin
         int n = 0;
         clear_eb();
         eb[0]  = 32'h6162_6380;
         eb[15] = 32'h0000_0018;
         push_block(1'b1);
         do_start();
         send_word(32'h6162_6300, 1'b1, 2'b11);
         @(negedge clk);
         while (!(bus.w_valid === 1'b1 && bus.w_idx == 4'd7) && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("abort_reach_idx7", {63'd0, (n < 200)}, 64'd1);
         #2;
         rst_n = 1'b0;
         #1;
         chk("abort_w_valid", {63'd0, bus.w_valid}, 64'd0);
         chk("abort_soc",     {63'd0, bus.soc},     64'd0);
         chk("abort_busy",    {63'd0, bus.busy},    64'd0);
         exp_q.delete();
         @(negedge clk);
         rst_n = 1'b1;
         repeat (10) @(negedge clk);
         chk("abort_stay_idle", {63'd0, bus.busy}, 64'd0);
         push_block(1'b1);
         do_start();
         send_word(32'h6162_6300, 1'b1, 2'b11);
         wait_idle("abort_abc_idle");
      end

      // in_valid held through padding, emission and idle must not change the length
      clear_eb();
      eb[0]  = 32'h6162_6380;
      eb[15] = 32'h0000_0018;
      push_block(1'b1);
      do_start();
      send_word(32'h6162_6300, 1'b1, 2'b11);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      bus.in_last  = 1'b1;
      bus.in_bytes = 2'b00;
      wait_idle("ignore_idle");
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("ignore_stay_idle", {63'd0, bus.busy}, 64'd0);

      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
